// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline-control definitions: hazard FSM encodings and RV32I opcodes.
// Pure declarations; no logic, no latency, no backpressure.
package hazard_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LU_BUBBLE = 2'd1,
    MEM_WAIT  = 2'd2
  } hz_state_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
// One-cycle update latency; no backpressure.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush control for the 5-stage pipeline: memory wait > redirect > load-use.
// Controls are combinational (zero latency); a stuck memory access stalls indefinitely.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_use_flag,
  input  logic             redirect_E,
  input  logic             dmem_req_M,
  input  logic             dmem_ready_M,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             stall_M,
  output logic             flush_D,
  output logic             flush_E,
  output logic             flush_W,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int WC_W = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(MEM_TIMEOUT - 1);
  localparam logic [WC_W-1:0] WC_ERR = WC_W'(MEM_TIMEOUT - 2);

  hz_state_e       state_q, state_d;
  logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            err_q;
  logic            mem_wait;
  logic            redirect_take;

  assign mem_wait      = dmem_req_M & ~dmem_ready_M;
  assign redirect_take = rst_n & redirect_E & ~mem_wait;

  always_comb begin
    stall_F    = 1'b0;
    stall_D    = 1'b0;
    stall_E    = 1'b0;
    stall_M    = 1'b0;
    flush_D    = 1'b0;
    flush_E    = 1'b0;
    flush_W    = 1'b0;
    state_d    = RUN;
    wait_cnt_d = '0;

    if (!rst_n) begin
      // Drain the pipeline to bubbles while held in reset.
      flush_D = 1'b1;
      flush_E = 1'b1;
      flush_W = 1'b1;
    end else if (mem_wait) begin
      stall_F = 1'b1;
      stall_D = 1'b1;
      stall_E = 1'b1;
      stall_M = 1'b1;
      flush_W = 1'b1;
      state_d = MEM_WAIT;
    end else if (redirect_E) begin
      flush_D = 1'b1;
      flush_E = 1'b1;
    end else if (load_use_flag) begin
      stall_F = 1'b1;
      stall_D = 1'b1;
      flush_E = 1'b1;
      state_d = LU_BUBBLE;
    end

    // wait_cnt holds the number of wait cycles already completed in this stall.
    if (rst_n && mem_wait) begin
      if (state_q != MEM_WAIT) begin
        wait_cnt_d = WC_W'(1);
      end else if (wait_cnt_q != WC_MAX) begin
        wait_cnt_d = wait_cnt_q + WC_W'(1);
      end else begin
        wait_cnt_d = wait_cnt_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (mem_wait && (wait_cnt_q == WC_ERR)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign mem_timeout_err = err_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_F),
    .q     (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (redirect_take),
    .q     (flush_events)
  );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl against a priority-rule reference model.
module tb_hazard_stall_ctrl;
  import hazard_stall_ctrl_pkg::*;

  localparam int CNT_W = 4;
  localparam int TO    = 4;
  localparam int SAT   = 15;

  logic             clk;
  logic             rst_n;
  logic             load_use_flag;
  logic             redirect_E;
  logic             dmem_req_M;
  logic             dmem_ready_M;
  logic             stall_F, stall_D, stall_E, stall_M;
  logic             flush_D, flush_E, flush_W;
  logic             mem_timeout_err;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  int        vectors     = 0;
  int        miscompares = 0;
  int        m_sc, m_fe, m_run;
  bit        m_err;
  hz_state_e m_state;

  hazard_stall_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .load_use_flag   (load_use_flag),
    .redirect_E      (redirect_E),
    .dmem_req_M      (dmem_req_M),
    .dmem_ready_M    (dmem_ready_M),
    .stall_F         (stall_F),
    .stall_D         (stall_D),
    .stall_E         (stall_E),
    .stall_M         (stall_M),
    .flush_D         (flush_D),
    .flush_E         (flush_E),
    .flush_W         (flush_W),
    .mem_timeout_err (mem_timeout_err),
    .stall_cycles    (stall_cycles),
    .flush_events    (flush_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Order: {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W}
  function automatic logic [6:0] exp_ctrl(bit lu, bit rd, bit req, bit rdy);
    if (req && !rdy) return 7'b1111_001;
    if (rd)          return 7'b0000_110;
    if (lu)          return 7'b1100_010;
    return 7'b0000_000;
  endfunction

  function automatic logic [6:0] obs_ctrl();
    return {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W};
  endfunction

  task automatic model_reset();
    m_sc = 0; m_fe = 0; m_run = 0; m_err = 0; m_state = RUN;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".stall_cycles"}, 32'(stall_cycles), 32'(m_sc));
    check({tag, ".flush_events"}, 32'(flush_events), 32'(m_fe));
    check({tag, ".err"}, 32'(mem_timeout_err), 32'(m_err));
    check({tag, ".state"}, 32'(dut.state_q), 32'(m_state));
  endtask

  task automatic step(input string tag, input bit lu, input bit rd, input bit req, input bit rdy);
    logic [6:0] e;
    bit mw;
    @(negedge clk);
    load_use_flag = lu; redirect_E = rd; dmem_req_M = req; dmem_ready_M = rdy;
    #1;
    e  = exp_ctrl(lu, rd, req, rdy);
    mw = req && !rdy;
    check({tag, ".ctrl"}, 32'(obs_ctrl()), 32'(e));
    @(posedge clk);
    if (e[6])      m_sc = (m_sc < SAT) ? m_sc + 1 : SAT;
    if (rd && !mw) m_fe = (m_fe < SAT) ? m_fe + 1 : SAT;
    m_run = mw ? m_run + 1 : 0;
    if (m_run >= TO - 1) m_err = 1;
    m_state = mw ? MEM_WAIT : (rd ? RUN : (lu ? LU_BUBBLE : RUN));
    #1;
    check_regs(tag);
  endtask

  task automatic do_reset(input string tag, input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    load_use_flag = 1'($urandom); redirect_E = 1'($urandom);
    dmem_req_M = 1'($urandom); dmem_ready_M = 1'($urandom);
    model_reset();
    #1;
    check({tag, ".ctrl"}, 32'(obs_ctrl()), 32'(7'b0000_111));
    check_regs(tag);
    repeat (cycles) @(posedge clk);
    #1;
    check({tag, ".held_ctrl"}, 32'(obs_ctrl()), 32'(7'b0000_111));
    check_regs({tag, ".held"});
    @(negedge clk);
    load_use_flag = 0; redirect_E = 0; dmem_req_M = 0; dmem_ready_M = 0;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    load_use_flag = 0; redirect_E = 0; dmem_req_M = 0; dmem_ready_M = 0;
    model_reset();

    // T1: reset held three cycles, then idle operation.
    do_reset("t1_rst", 3);
    step("t1_idle", 0, 0, 0, 0);

    // T2: single load-use cycle.
    do_reset("t2_rst", 1);
    step("t2_lu", 1, 0, 0, 0);
    check("t2_sc_one", 32'(stall_cycles), 32'd1);
    step("t2_after", 0, 0, 0, 0);

    // T3: redirect wins over load-use.
    do_reset("t3_rst", 1);
    step("t3_rd_lu", 1, 1, 0, 0);
    check("t3_fe_one", 32'(flush_events), 32'd1);

    // T4: three wait cycles with redirect pending, then ready.
    do_reset("t4_rst", 1);
    for (int i = 0; i < 3; i++) step("t4_wait", 0, 1, 1, 0);
    step("t4_ready", 0, 1, 1, 1);
    check("t4_sc_three", 32'(stall_cycles), 32'd3);
    check("t4_fe_one", 32'(flush_events), 32'd1);

    // Ready in the first request cycle: no stall at all.
    step("t4_fast", 0, 0, 1, 1);

    // T5: memory never ready; error on the 4th wait cycle, cleared by async reset.
    do_reset("t5_rst", 1);
    for (int i = 0; i < 6; i++) step("t5_wait", 0, 0, 1, 0);
    check("t5_err_set", 32'(mem_timeout_err), 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("t5_async_err", 32'(mem_timeout_err), 32'd0);
    check("t5_async_state", 32'(dut.state_q), 32'(RUN));
    check("t5_async_ctrl", 32'(obs_ctrl()), 32'(7'b0000_111));
    check("t5_async_sc", 32'(stall_cycles), 32'd0);
    do_reset("t5_rst2", 2);

    // T6: stall counter saturates.
    for (int i = 0; i < 20; i++) step("t6_lu", 1, 0, 0, 0);
    check("t6_sat", 32'(stall_cycles), 32'hF);

    // Randomized traffic with occasional resets.
    do_reset("rnd_rst0", 1);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 4) begin
        do_reset("rnd_rst", $urandom_range(1, 2));
      end else begin
        step("rnd",
             $urandom_range(0, 99) < 30,
             $urandom_range(0, 99) < 25,
             $urandom_range(0, 99) < 45,
             $urandom_range(0, 99) < 40);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
